// File: rtl/adder_station_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_station_if
// Description : Bundle of the issue bus, register-status lookup, snooped
//               per-slot data bus and result broadcast seen by one adder
//               reservation station.
//               master : reorder-buffer / register-file side
//               slave  : the reservation station
// Ports       : CDB_inst_fu/inst/RBindex  issue bus
//               numj/numk -> vj/vk/qj/qk  operand lookup (comb. response)
//               CDB_data_data/valid       snooped result lanes
//               busy, res_data/index/valid station status and result
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_station_if #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 15,
    parameter int RB_INDEX  = 4,
    parameter int FU_INDEX  = 4,
    parameter int REG_INDEX = 5
);
    logic [FU_INDEX-1:0]          CDB_inst_fu;
    logic [WORD_SIZE-1:0]         CDB_inst_inst;
    logic [RB_INDEX-1:0]          CDB_inst_RBindex;
    logic [REG_INDEX-1:0]         numj;
    logic [REG_INDEX-1:0]         numk;
    logic [WORD_SIZE-1:0]         vj;
    logic [WORD_SIZE-1:0]         vk;
    logic [RB_INDEX-1:0]          qj;
    logic [RB_INDEX-1:0]          qk;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic                         busy;
    logic [WORD_SIZE-1:0]         res_data;
    logic [RB_INDEX-1:0]          res_index;
    logic                         res_valid;

    modport master (
        output CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
        output vj, vk, qj, qk, CDB_data_data, CDB_data_valid,
        input  numj, numk, busy, res_data, res_index, res_valid
    );

    modport slave (
        input  CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
        input  vj, vk, qj, qk, CDB_data_data, CDB_data_valid,
        output numj, numk, busy, res_data, res_index, res_valid
    );
endinterface
`default_nettype wire

// File: rtl/adder_station.sv
`default_nettype none
// ============================================================================
// Module      : adder_station
// Description : Single reservation station with a fixed-latency integer
//               adder/subtractor. Accepts ADD/SUB/ADDI/SUBI addressed to
//               FU_ID, resolves operands from the register-status port or
//               by snooping the result lanes, executes for LATENCY cycles and
//               broadcasts the result tagged with its reorder-buffer slot.
// Ports       : clk    - clock
//               reset  - asynchronous active-high reset
//               flush  - synchronous squash of the held instruction
//               bus    - adder_station_if.slave (issue, lookup, snoop, result)
// Revision    : 1.0 - initial release
// ============================================================================
module adder_station #(
    parameter int                  WORD_SIZE = 32,
    parameter int                  RB_SIZE   = 15,
    parameter int                  RB_INDEX  = 4,
    parameter int                  FU_INDEX  = 4,
    parameter int                  REG_INDEX = 5,
    parameter logic [FU_INDEX-1:0] FU_ID     = '0,
    parameter logic [RB_INDEX-1:0] READY     = 4'hF,
    parameter int                  LATENCY   = 2,
    parameter logic [5:0]          OP_ADD    = 6'd0,
    parameter logic [5:0]          OP_SUB    = 6'd1,
    parameter logic [5:0]          OP_ADDI   = 6'd5,
    parameter logic [5:0]          OP_SUBI   = 6'd6
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         flush,
    adder_station_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Counter only has to hold LATENCY-1.
    localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]           state_q,     state_d;
    logic [5:0]           op_q,        op_d;
    logic [RB_INDEX-1:0]  rb_q,        rb_d;
    logic [WORD_SIZE-1:0] vj_q,        vj_d;
    logic [WORD_SIZE-1:0] vk_q,        vk_d;
    logic [RB_INDEX-1:0]  qj_q,        qj_d;
    logic [RB_INDEX-1:0]  qk_q,        qk_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 busy_q,      busy_d;
    logic [WORD_SIZE-1:0] res_data_q,  res_data_d;
    logic [RB_INDEX-1:0]  res_index_q, res_index_d;
    logic                 res_valid_q, res_valid_d;
    logic [REG_INDEX-1:0] numj_q,      numj_d;
    logic [REG_INDEX-1:0] numk_q,      numk_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [5:0]           w_opcode;
    logic [REG_INDEX-1:0] w_rs;
    logic [REG_INDEX-1:0] w_rt;
    logic [WORD_SIZE-1:0] w_imm_ext;
    logic                 w_sel;
    logic                 w_is_imm;
    logic                 w_op_ok;
    logic                 w_accept;
    logic                 w_unused_rd;

    assign w_opcode    = bus.CDB_inst_inst[31:26];
    assign w_rs        = bus.CDB_inst_inst[20:16];
    assign w_rt        = bus.CDB_inst_inst[15:11];
    assign w_imm_ext   = {{(WORD_SIZE-16){bus.CDB_inst_inst[15]}}, bus.CDB_inst_inst[15:0]};
    assign w_unused_rd = ^bus.CDB_inst_inst[25:21];
    assign w_sel       = (bus.CDB_inst_fu == FU_ID);
    assign w_is_imm    = (w_opcode == OP_ADDI) || (w_opcode == OP_SUBI);
    assign w_op_ok     = w_is_imm || (w_opcode == OP_ADD) || (w_opcode == OP_SUB);
    assign w_accept    = w_sel && !busy_q && !flush && w_op_ok;

    // ------------------------------------------------------------------
    // Operand resolution. In IDLE the candidate tags/values come straight
    // from the issue bus (immediate forms carry a ready k operand); in WAIT
    // they are the held ones. Either way a valid matching lane overrides,
    // which gives same-cycle forwarding at issue for free.
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] w_cand_vj, w_cand_vk;
    logic [RB_INDEX-1:0]  w_cand_qj, w_cand_qk;
    logic                 w_j_hit,   w_k_hit;
    logic [WORD_SIZE-1:0] w_j_lane,  w_k_lane;
    logic [WORD_SIZE-1:0] w_j_val,   w_k_val;
    logic [RB_INDEX-1:0]  w_j_tag,   w_k_tag;
    logic                 w_both_ready;

    always_comb begin : p_snoop
        if (state_q == ST_IDLE) begin
            w_cand_vj = bus.vj;
            w_cand_qj = bus.qj;
            w_cand_vk = w_is_imm ? w_imm_ext : bus.vk;
            w_cand_qk = w_is_imm ? READY     : bus.qk;
        end else begin
            w_cand_vj = vj_q;
            w_cand_qj = qj_q;
            w_cand_vk = vk_q;
            w_cand_qk = qk_q;
        end

        w_j_hit  = 1'b0;
        w_k_hit  = 1'b0;
        w_j_lane = '0;
        w_k_lane = '0;
        for (int i = 0; i < RB_SIZE; i++) begin
            if (w_cand_qj != READY && w_cand_qj == RB_INDEX'(i) && bus.CDB_data_valid[i]) begin
                w_j_hit  = 1'b1;
                w_j_lane = bus.CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
            end
            if (w_cand_qk != READY && w_cand_qk == RB_INDEX'(i) && bus.CDB_data_valid[i]) begin
                w_k_hit  = 1'b1;
                w_k_lane = bus.CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end

        w_j_val      = w_j_hit ? w_j_lane : w_cand_vj;
        w_j_tag      = w_j_hit ? READY    : w_cand_qj;
        w_k_val      = w_k_hit ? w_k_lane : w_cand_vk;
        w_k_tag      = w_k_hit ? READY    : w_cand_qk;
        w_both_ready = (w_j_tag == READY) && (w_k_tag == READY);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin : p_state
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            rb_q        <= '0;
            vj_q        <= '0;
            vk_q        <= '0;
            qj_q        <= READY;
            qk_q        <= READY;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
            res_index_q <= '0;
            res_valid_q <= 1'b0;
            numj_q      <= '0;
            numk_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rb_q        <= rb_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            res_valid_q <= res_valid_d;
            numj_q      <= numj_d;
            numk_q      <= numk_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next
        state_d     = state_q;
        op_d        = op_q;
        rb_d        = rb_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        res_valid_d = 1'b0;
        numj_d      = w_sel ? w_rs : numj_q;
        numk_d      = w_sel ? w_rt : numk_q;

        if (flush) begin
            // Squash beats both issue and completion.
            state_d = ST_IDLE;
            qj_d    = READY;
            qk_d    = READY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        op_d = w_opcode;
                        rb_d = bus.CDB_inst_RBindex;
                        vj_d = w_j_val;
                        qj_d = w_j_tag;
                        vk_d = w_k_val;
                        qk_d = w_k_tag;
                        if (w_both_ready) begin
                            state_d = ST_EXEC;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    vj_d = w_j_val;
                    qj_d = w_j_tag;
                    vk_d = w_k_val;
                    qk_d = w_k_tag;
                    if (w_both_ready) begin
                        state_d = ST_EXEC;
                        cnt_d   = CNT_INIT;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        res_data_d  = (op_q == OP_SUB || op_q == OP_SUBI) ? (vj_q - vk_q)
                                                                          : (vj_q + vk_q);
                        res_index_d = rb_q;
                        res_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    // ------------------------------------------------------------------
    // Outputs. Lookup indices follow the issue bus while it addresses this
    // unit and otherwise show the last indices it presented.
    // ------------------------------------------------------------------
    always_comb begin : p_out
        bus.numj      = w_sel ? w_rs : numj_q;
        bus.numk      = w_sel ? w_rt : numk_q;
        bus.busy      = busy_q;
        bus.res_data  = res_data_q;
        bus.res_index = res_index_q;
        bus.res_valid = res_valid_q;
    end

endmodule
`default_nettype wire

// File: doc/adder_station.md
Name: adder_station

Overview:
- Single reservation station plus integer adder/subtractor functional unit, sitting directly downstream of the reorder buffer's issue port.
- Accepts one ADD/SUB/ADDI/SUBI instruction addressed to its FU number and tags it with the reorder-buffer index.
- Resolves operands from the register-status read port or by snooping the per-slot data bus.
- Executes with fixed latency, then broadcasts the result for that reorder-buffer slot.

Parameters:
- WORD_SIZE, 32, data and instruction width
- RB_SIZE, 15, reorder-buffer slots; bus lanes 0..RB_SIZE-1
- RB_INDEX, 4, reorder-buffer index width
- FU_INDEX, 4, FU number width
- REG_INDEX, 5, architectural register index width
- FU_ID, 0, this unit's FU number
- READY, 4'hF, tag value meaning "operand value valid"
- LATENCY, 2, execute cycles (>=1)
- OP_ADD/OP_SUB/OP_ADDI/OP_SUBI, 6'd0/6'd1/6'd5/6'd6, opcode encodings in inst[31:26]

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous squash of held instruction
- CDB_inst_fu  in  FU_INDEX  target FU of the issue bus
- CDB_inst_inst  in  WORD_SIZE  issued instruction
- CDB_inst_RBindex  in  RB_INDEX  destination reorder-buffer slot
- numj, numk  out  REG_INDEX  register indices for operand lookup
- vj, vk  in  WORD_SIZE  register values (combinational response to numj/numk)
- qj, qk  in  RB_INDEX  producer tags (READY if value valid)
- CDB_data_data  in  RB_SIZE*WORD_SIZE  snooped result lanes; lane i at bits [i*WORD_SIZE +: WORD_SIZE]
- CDB_data_valid  in  RB_SIZE  per-lane valid
- busy  out  1  station occupied
- res_data  out  WORD_SIZE  result
- res_index  out  RB_INDEX  slot the result belongs to
- res_valid  out  1  one-cycle result strobe; the top level routes it to CDB_data_valid[res_index]

Behaviour:
- Instruction fields:
  - opcode [31:26], rd [25:21], rs [20:16], rt [15:11], imm [15:0].
  - imm is sign-extended to WORD_SIZE.
- Reset (async): state IDLE; busy=0, res_valid=0, res_data=0, res_index=0; internal tags = READY; counter=0.
- Operand lookup:
  - numj = rs and numk = rt of CDB_inst_inst, combinational.
  - When CDB_inst_fu != FU_ID, numj and numk hold their last value.
- States:
  - IDLE: issue accepted on a clk edge when CDB_inst_fu==FU_ID, busy==0, flush==0 and opcode is one of the four.
    - On accept, latch the opcode and RBindex.
    - j operand: latch vj/qj.
    - k operand: for register forms latch vk/qk; for immediate forms latch the sign-extended imm with tag READY.
    - Same-cycle forwarding: if a latched tag q!=READY and CDB_data_valid[q]=1, latch lane q data with tag READY instead.
    - If both tags are READY, go to EXEC with cnt=LATENCY-1; otherwise go to WAIT.
    - Unknown opcode addressed to FU_ID: ignored, state stays IDLE, busy stays 0.
  - WAIT: each edge, capture each pending operand whose lane is valid and set its tag to READY.
    - When both tags are READY after this edge's captures, go to EXEC with cnt=LATENCY-1 on the same edge.
  - EXEC: if cnt>0, decrement.
    - If cnt==0: compute res_data (ADD/ADDI j+k, SUB/SUBI j-k, modulo 2^WORD_SIZE), set res_index, res_valid=1, go to DONE.
  - DONE: res_valid=0, go to IDLE; res_data and res_index hold.
- busy = (state != IDLE), registered.
  - Asserts the edge after acceptance; deasserts on the edge leaving DONE.
  - A new instruction is therefore accepted no earlier than the edge after busy falls.
- Latency with ready operands: accept at edge E, res_valid high from edge E+LATENCY to E+LATENCY+1.
- flush: on the clk edge, return to IDLE, res_valid=0, tags=READY. Priority over issue and completion; a flushed instruction never broadcasts.
- Simultaneous valid on both pending lanes in one cycle: both captured on the same edge.
- qj==qk pending: a single lane event satisfies both.
- res_valid is never high on two consecutive cycles.

Test Plan:
- Reset mid-EXEC → busy=0, res_valid=0 immediately, no broadcast afterwards.
- ADD rd=3 rs=1 rt=2 to FU_ID, RBindex=5, vj=10, vk=7, qj=qk=READY, LATENCY=2 → res_valid high exactly one cycle at E+2, res_data=17, res_index=5; busy high E+1..E+3.
- SUBI rs=4 imm=16'hFFFF, vj=0, qj=READY → res_data=1 (0-(-1)); ADD vj=32'hFFFFFFFF, vk=1 → res_data=0.
- ADD with qj=3, qk=READY; CDB_data_valid[3] pulses 4 cycles later with lane-3 data 100, vk=1 → capture on that edge, result 101 at capture+2.
- qj=7 with CDB_data_valid[7]=1 during the issue cycle, lane 7 = 42, vk=8 → no WAIT, result 50 at E+2.
- Second issue to FU_ID while busy → ignored, first result unaffected; flush while in WAIT → busy falls the next edge, res_valid never asserts.
